// File: rtl/rr_mux_n_pkg.sv
// Shared constants for the round-robin channel mux: default geometry and mode encodings.
// No logic; imported by the interface, arbiter and top.
package rr_mux_n_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_mux_n_if.sv
// Channel-side and output-side handshake bundle of rr_mux_n; master drives inputs, slave is the mux.
// Pure wiring, no latency; valid/ready on both sides.
interface rr_mux_n_if
    import rr_mux_n_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SW    = $clog2(N)
);

    logic               mode;
    logic [SW-1:0]      sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/rr_mux_n_arbiter.sv
// Combinational grant logic: static select or round-robin search starting at ptr; zero latency.
// en low (output register busy or reset) forces no grant, which is how backpressure reaches in_ready.
module rr_arbiter
    import rr_mux_n_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    input  logic          mode_i,
    input  logic [SW-1:0] sel_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] grant_idx_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        if (en_i) begin
            if (mode_i == MODE_RR) begin
                for (int k = 0; k < N; k++) begin
                    idx = (int'(ptr_i) + k) % N;
                    if (!found && req_i[idx]) begin
                        found        = 1'b1;
                        grant_o[idx] = 1'b1;
                        grant_idx_o  = SW'(idx);
                    end
                end
            end else begin
                // Indices >= N match no channel, so an out-of-range sel grants nothing.
                for (int i = 0; i < N; i++) begin
                    if (i == int'(sel_i) && req_i[i]) begin
                        grant_o[i]  = 1'b1;
                        grant_idx_o = sel_i;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-to-1 channel mux with static or round-robin selection into a single output register; latency 1 cycle.
// Accepts a new word whenever the register is empty or drained this cycle; a stall holds the word and drops in_ready.
module rr_mux_n
    import rr_mux_n_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SW    = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst,
    rr_mux_n_if.slave bus
);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic             xfer;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load = ~out_valid_q | bus.out_ready;

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req_i       (bus.in_valid),
        .ptr_i       (ptr_q),
        .mode_i      (bus.mode),
        .sel_i       (bus.sel),
        .en_i        (load & ~rst),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign xfer = |grant;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = grant_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode == MODE_RR) begin
                ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
            end
        end else if (load) begin
            // Drained with nothing to replace it: drop valid, keep last data/chan.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed vector bench for rr_mux_n: a 4-channel and a 3-channel instance sharing clock and reset.
module tb_rr_mux_n;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_chan;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    vec_t v4[13];
    vec_t v3[8];

    rr_mux_n_if #(.WIDTH(8), .N(4)) bus4 ();
    rr_mux_n_if #(.WIDTH(8), .N(3)) bus3 ();

    rr_mux_n #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_mux_n #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply4(input int i, input vec_t v);
        @(negedge clk);
        bus4.mode      = v.mode;
        bus4.sel       = v.sel;
        bus4.in_valid  = v.valid;
        bus4.out_ready = v.ordy;
        #1;
        chk($sformatf("n4 v%0d in_ready", i), 32'(bus4.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("n4 v%0d out_valid", i), 32'(bus4.out_valid), 32'(v.exp_ov));
        chk($sformatf("n4 v%0d out_chan", i), 32'(bus4.out_chan), 32'(v.exp_chan));
        chk($sformatf("n4 v%0d out_data", i), 32'(bus4.out_data), 32'(v.exp_data));
    endtask

    task automatic apply3(input int i, input vec_t v);
        @(negedge clk);
        bus3.mode      = v.mode;
        bus3.sel       = v.sel;
        bus3.in_valid  = v.valid[2:0];
        bus3.out_ready = v.ordy;
        #1;
        chk($sformatf("n3 v%0d in_ready", i), 32'(bus3.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("n3 v%0d out_valid", i), 32'(bus3.out_valid), 32'(v.exp_ov));
        chk($sformatf("n3 v%0d out_chan", i), 32'(bus3.out_chan), 32'(v.exp_chan));
        chk($sformatf("n3 v%0d out_data", i), 32'(bus3.out_data), 32'(v.exp_data));
    endtask

    initial begin
        // mode, sel, in_valid, out_ready -> in_ready, out_valid, out_chan, out_data
        v4[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        v4[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        v4[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        v4[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        v4[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        v4[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
        v4[6]  = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        v4[7]  = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
        v4[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
        v4[9]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};
        v4[10] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h22};
        v4[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
        v4[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};

        v3[0]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1};
        v3[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1};
        v3[2]  = '{1'b0, 2'd2, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC3};
        v3[3]  = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1};
        v3[4]  = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB2};
        v3[5]  = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC3};
        v3[6]  = '{1'b1, 2'd0, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1};
        v3[7]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1};

        bus4.mode      = 1'b0;
        bus4.sel       = 2'd2;
        bus4.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b1;
        bus3.mode      = 1'b0;
        bus3.sel       = 2'd0;
        bus3.in_data   = {8'hC3, 8'hB2, 8'hA1};
        bus3.in_valid  = 3'b000;
        bus3.out_ready = 1'b1;

        // Reset state, with valid inputs present to show in_ready is gated.
        #1;
        chk("reset out_valid", 32'(bus4.out_valid), 32'd0);
        chk("reset out_data", 32'(bus4.out_data), 32'd0);
        chk("reset out_chan", 32'(bus4.out_chan), 32'd0);
        chk("reset in_ready", 32'(bus4.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) apply4(i, v4[i]);

        // Backpressure: park 8'h3C, stall three cycles with new data waiting.
        @(negedge clk);
        bus4.mode      = 1'b0;
        bus4.sel       = 2'd0;
        bus4.in_valid  = 4'b0001;
        bus4.in_data   = {8'h44, 8'hA5, 8'h22, 8'h3C};
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp load data", 32'(bus4.out_data), 32'h3C);
        chk("bp load valid", 32'(bus4.out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus4.out_ready = 1'b0;
            bus4.in_valid  = 4'b1111;
            bus4.in_data   = {8'h44, 8'hA5, 8'h22, 8'h55};
            #1;
            chk($sformatf("bp stall%0d in_ready", c), 32'(bus4.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp stall%0d data", c), 32'(bus4.out_data), 32'h3C);
            chk($sformatf("bp stall%0d valid", c), 32'(bus4.out_valid), 32'd1);
        end
        @(negedge clk);
        bus4.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(bus4.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("bp release data", 32'(bus4.out_data), 32'h55);
        chk("bp release valid", 32'(bus4.out_valid), 32'd1);

        // Reset mid-stream with a word held; pointer was left at 1 by v4[12].
        @(negedge clk);
        bus4.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 32'(bus4.out_valid), 32'd0);
        chk("midrst out_data", 32'(bus4.out_data), 32'd0);
        chk("midrst in_ready", 32'(bus4.in_ready), 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        bus4.mode      = 1'b1;
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b1;
        #1;
        chk("postrst in_ready", 32'(bus4.in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("postrst out_chan", 32'(bus4.out_chan), 32'd0);
        chk("postrst out_valid", 32'(bus4.out_valid), 32'd1);

        for (int i = 0; i < 8; i++) apply3(i, v3[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels (N >= 2).
REQ-003 Parameter SW, default $clog2(N), width of channel-index signals.
REQ-004 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 mode  input  1  0 = static select by sel; 1 = round-robin arbitration.
REQ-008 sel  input  SW  channel index used when mode=0.
REQ-009 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_valid  input  N  per-channel data-valid.
REQ-011 in_ready  output  N  per-channel accept; transfer on channel i when in_valid[i] & in_ready[i].
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_chan  output  SW  index of the channel that produced out_data.
REQ-014 out_valid  output  1  out_data/out_chan hold a word.
REQ-015 out_ready  input  1  downstream accept; transfer when out_valid & out_ready.

Function
REQ-016 The block SHALL set load = ~out_valid | out_ready, combinationally.
REQ-017 The block SHALL grant at most one channel per cycle; in_ready SHALL be one-hot or zero, and in_ready[i] = grant[i] & load.
REQ-018 mode=0: grant = channel sel iff in_valid[sel]; no grant if sel >= N.
REQ-019 mode=1: grant = first channel with in_valid set, searching ptr, ptr+1, ..., wrapping modulo N.
REQ-020 ptr SHALL update to (granted index + 1) mod N only on an input transfer in mode=1; ptr is unchanged in mode=0.
REQ-021 On an input transfer, out_data, out_chan and out_valid=1 SHALL load at the next clk edge; latency is 1 cycle.
REQ-022 When load=1 and no grant, out_valid SHALL go 0 at the next edge; out_data and out_chan SHALL hold their values.
REQ-023 When out_valid=1 and out_ready=0 (stall), out_data, out_chan and out_valid SHALL be held stable and in_ready SHALL be 0.
REQ-024 Full throughput: with out_ready held at 1 and continuous valid input, one word SHALL transfer every cycle.
REQ-025 A change of mode or sel SHALL affect only the arbitration in the same cycle; held output data is unaffected.
REQ-026 in_ready SHALL NOT depend on in_valid of non-granted channels combinationally beyond the arbiter search; no combinational path from out_ready to out_data.

Reset
REQ-027 While rst=1: out_valid=0, out_data=0, out_chan=0, ptr=0, in_ready=0 (asynchronous, immediate).
REQ-028 Reset mid-operation SHALL discard any held output word; no transfer occurs in a cycle where rst=1.
REQ-029 The first arbitration after reset release in mode=1 SHALL start at channel 0.

Structure
REQ-030 A shared package SHALL hold the default WIDTH/N constants and the mode encodings (MODE_SEL=0, MODE_RR=1).
REQ-031 Arbitration SHALL be a sub-module rr_arbiter (inputs req[N], ptr, mode, sel, en; outputs grant[N] one-hot, grant_idx[SW]).
REQ-032 The ptr register and output register SHALL reside in rr_mux_n.

Verification
REQ-033 Static select: mode=0, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_chan=2, out_valid=1.
REQ-034 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Round-robin skip/wrap: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2; then in_valid=4'b1001 -> grant ch3.
REQ-036 Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 3 cycles -> out_data stays 8'h3C and in_ready=0 throughout; on out_ready=1, the next word loads the following cycle.
REQ-037 Reset mid-stream: assert rst between edges with out_valid=1 -> out_valid=0, out_data=0 immediately; after release, mode=1 with in_valid=4'b1111 -> first out_chan=0.
REQ-038 Out-of-range/idle: N=3, mode=0, sel=3 -> in_ready=0; in_valid=0 with out_ready=1 -> out_valid drops to 0 after one cycle.
